// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi211_bist_pkg.sv
// Shared types and golden model for the aoi211 BIST sequencer.
package gf180mcu_fd_sc_mcu7t5v0__aoi211_bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    // Bit positions of each cell pin inside the 4-bit stimulus vector {A1,A2,B,C}.
    localparam int VEC_A1 = 3;
    localparam int VEC_A2 = 2;
    localparam int VEC_B  = 1;
    localparam int VEC_C  = 0;

    function automatic logic aoi211_ref(input logic a1, input logic a2,
                                        input logic b, input logic c);
        return !((a1 & a2) | b | c);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi211_bist_vecgen.sv
// Stimulus sequencer: settle/vector/pass counters, alternating sweep direction per pass.
module gf180mcu_fd_sc_mcu7t5v0__aoi211_bist_vecgen #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_en,
    output logic [3:0] o_vec,
    output logic       o_sample_strobe,
    output logic       o_last_sample
);

    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [PW-1:0] PASS_MAX   = PW'(NUM_PASSES - 1);

    logic [SW-1:0] r_settle;
    logic [PW-1:0] r_pass;
    logic          r_desc;
    logic [3:0]    r_vec;
    logic          w_pass_end;

    assign w_pass_end      = r_desc ? (r_vec == 4'd0) : (r_vec == 4'hF);
    assign o_sample_strobe = i_en && (r_settle == SETTLE_MAX);
    assign o_last_sample   = o_sample_strobe && w_pass_end && (r_pass == PASS_MAX);
    assign o_vec           = r_vec;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_settle <= '0;
            r_pass   <= '0;
            r_desc   <= 1'b0;
            r_vec    <= 4'd0;
        end else if (i_load) begin
            r_settle <= '0;
            r_pass   <= '0;
            r_desc   <= 1'b0;
            r_vec    <= 4'd0;
        end else if (o_sample_strobe) begin
            r_settle <= '0;
            if (o_last_sample) begin
                r_vec  <= 4'd0;
                r_pass <= '0;
                r_desc <= 1'b0;
            end else if (w_pass_end) begin
                // The end vector of one pass is the start vector of the reversed next pass.
                r_pass <= r_pass + PW'(1);
                r_desc <= ~r_desc;
            end else begin
                r_vec <= r_desc ? (r_vec - 4'd1) : (r_vec + 4'd1);
            end
        end else if (i_en) begin
            r_settle <= r_settle + SW'(1);
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi211_bist.sv
// BIST sequencer for one aoi211 cell: run FSM, ZN comparator, saturating error count, first-fail capture.
module gf180mcu_fd_sc_mcu7t5v0__aoi211_bist
    import gf180mcu_fd_sc_mcu7t5v0__aoi211_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN_OBS,
    output logic             A1,
    output logic             A2,
    output logic             B,
    output logic             C,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_SEEN,
    output logic [3:0]       FAIL_VEC,
    inout  wire              VDD,
    inout  wire              VSS
);

    state_t           r_state;
    logic             w_go;
    logic             w_en;
    logic             w_strobe;
    logic             w_last;
    logic             w_mismatch;
    logic [3:0]       w_vec;
    logic [ERR_W-1:0] w_err_next;
    logic             w_pwr_unused;

    assign w_pwr_unused = VDD ^ VSS;

    assign w_go = START && (r_state != RUN);
    assign w_en = (r_state == RUN);

    gf180mcu_fd_sc_mcu7t5v0__aoi211_bist_vecgen #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .NUM_PASSES   (NUM_PASSES)
    ) u_vecgen (
        .i_clk          (CLK),
        .i_rst          (RST),
        .i_load         (w_go),
        .i_en           (w_en),
        .o_vec          (w_vec),
        .o_sample_strobe(w_strobe),
        .o_last_sample  (w_last)
    );

    assign A1 = w_vec[VEC_A1];
    assign A2 = w_vec[VEC_A2];
    assign B  = w_vec[VEC_B];
    assign C  = w_vec[VEC_C];

    assign w_mismatch = w_strobe &&
        (ZN_OBS != aoi211_ref(w_vec[VEC_A1], w_vec[VEC_A2], w_vec[VEC_B], w_vec[VEC_C]));
    assign w_err_next = (w_mismatch && (ERR_CNT != '1)) ? (ERR_CNT + ERR_W'(1)) : ERR_CNT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_SEEN <= 1'b0;
            FAIL_VEC  <= 4'd0;
        end else begin
            case (r_state)
                IDLE, DONE_ST: begin
                    if (START) begin
                        r_state   <= RUN;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
                        PASS      <= 1'b0;
                        ERR_CNT   <= '0;
                        FAIL_SEEN <= 1'b0;
                        FAIL_VEC  <= 4'd0;
                    end
                end
                RUN: begin
                    ERR_CNT <= w_err_next;
                    if (w_mismatch && !FAIL_SEEN) begin
                        FAIL_SEEN <= 1'b1;
                        FAIL_VEC  <= w_vec;
                    end
                    if (w_last) begin
                        r_state <= DONE_ST;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        PASS    <= (w_err_next == '0);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
